starfield_ctrl: RTL and testbench

STARFIELD_CTRL -- requirements
Module: starfield_ctrl

---
 rtl/starfield_ctrl.sv | 133 +++++++++++++
 tb/tb_starfield_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/starfield_ctrl.sv
// Starfield scroll controller: reloads the star LFSR every frame, then skips `offset` steps so the field scrolls.
// Define STARFIELD_PAUSE_EN to add a pause input that freezes the scroll offset.
module starfield_ctrl #(
  parameter int CORDW   = 16,
  parameter int LFSRW   = 17,
  parameter int FIELD_W = 512,
  parameter int FIELD_H = 256,
  parameter int SPDW    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic signed [CORDW-1:0] dx,
  input  logic signed [CORDW-1:0] dy,
  input  logic [SPDW-1:0]         speed,
`ifdef STARFIELD_PAUSE_EN
  input  logic                    pause,
`endif
  output logic                    lfsr_reload,
  output logic                    lfsr_en,
  output logic                    paint,
  output logic                    busy,
  output logic                    overrun
);

  localparam int OFFW = $clog2(FIELD_W);
  localparam logic signed [CORDW-1:0] FIELD_W_S = CORDW'(FIELD_W);
  localparam logic signed [CORDW-1:0] FIELD_H_S = CORDW'(FIELD_H);

  if (FIELD_W != (1 << OFFW) || LFSRW < 2) begin : g_bad_params
    $error("starfield_ctrl: FIELD_W must be a power of two and LFSRW at least 2");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SKIP, ARMED} state_t;

  state_t          state, state_d;
  logic [OFFW-1:0] offset, offset_d;
  logic [OFFW-1:0] skip_cnt, skip_cnt_d;
  logic            overrun_d;
  logic            lfsr_reload_d, lfsr_en_d, paint_d, busy_d;
  logic            field;
  logic            hold;

  // Signed test so that negative coordinates (blanking, borders) fall outside the field.
  function automatic logic in_field(input logic signed [CORDW-1:0] x,
                                    input logic signed [CORDW-1:0] y);
    return !x[CORDW-1] && !y[CORDW-1] && (x < FIELD_W_S) && (y < FIELD_H_S);
  endfunction

  function automatic logic [OFFW-1:0] wrap_add(input logic [OFFW-1:0] a,
                                               input logic [SPDW-1:0] b);
    logic [OFFW+SPDW-1:0] s;
    s = {{SPDW{1'b0}}, a} + {{OFFW{1'b0}}, b};
    return s[OFFW-1:0];
  endfunction

  assign field = in_field(dx, dy);

`ifdef STARFIELD_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    offset_d   = offset;
    skip_cnt_d = skip_cnt;
    overrun_d  = overrun;
    case (state)
      IDLE: begin
        if (frame_start) state_d = LOAD;
      end
      LOAD: begin
        if (frame_start) begin
          overrun_d = 1'b1;
        end else begin
          skip_cnt_d = offset;
          state_d    = (offset != '0) ? SKIP : ARMED;
        end
      end
      SKIP: begin
        skip_cnt_d = skip_cnt - OFFW'(1);
        if (frame_start) begin
          state_d   = LOAD;
          overrun_d = 1'b1;
        end else if (skip_cnt == OFFW'(1)) begin
          state_d = ARMED;
        end else if (field) begin
          // Visible area reached before the skip finished: paint now, scroll is off this frame.
          state_d   = ARMED;
          overrun_d = 1'b1;
        end
      end
      ARMED: begin
        if (frame_start) begin
          state_d = LOAD;
          if (!hold) offset_d = wrap_add(offset, speed);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    lfsr_reload_d = (state_d == LOAD);
    busy_d        = (state_d == LOAD) || (state_d == SKIP);
    paint_d       = (state_d == ARMED) && field;
    lfsr_en_d     = (state_d == SKIP) || paint_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      offset      <= '0;
      skip_cnt    <= '0;
      overrun     <= 1'b0;
      lfsr_reload <= 1'b0;
      lfsr_en     <= 1'b0;
      paint       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      offset      <= offset_d;
      skip_cnt    <= skip_cnt_d;
      overrun     <= overrun_d;
      lfsr_reload <= lfsr_reload_d;
      lfsr_en     <= lfsr_en_d;
      paint       <= paint_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_starfield_ctrl.sv
// Bench for starfield_ctrl: raster frames driven step by step, per-frame pulse counts checked against an offset model.
// Honours STARFIELD_PAUSE_EN when the design is built with it.
module tb_starfield_ctrl;

  localparam int CORDW = 16;
  localparam int LFSRW = 17;
  localparam int FW    = 32;
  localparam int FH    = 4;
  localparam int SPDW  = 8;

`ifdef STARFIELD_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    frame_start;
  logic signed [CORDW-1:0] dx, dy;
  logic [SPDW-1:0]         speed;
  logic                    pause;
  logic                    lfsr_reload, lfsr_en, paint, busy, overrun;

  starfield_ctrl #(
    .CORDW(CORDW), .LFSRW(LFSRW), .FIELD_W(FW), .FIELD_H(FH), .SPDW(SPDW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .dx(dx), .dy(dy), .speed(speed),
`ifdef STARFIELD_PAUSE_EN
    .pause(pause),
`endif
    .lfsr_reload(lfsr_reload), .lfsr_en(lfsr_en), .paint(paint), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_offset  = 0;
  bit m_armed   = 0;
  bit m_overrun = 0;

  int cnt_reload, cnt_skip, cnt_busy, cnt_paint, cnt_arm_en, cnt_both;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_reload = 0; cnt_skip = 0; cnt_busy = 0;
    cnt_paint = 0; cnt_arm_en = 0; cnt_both = 0;
  endtask

  // Drive one pixel clock, then sample the registered outputs just after the edge.
  task automatic step(input bit fs, input int x, input int y);
    frame_start = fs;
    dx = CORDW'(x);
    dy = CORDW'(y);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    if (lfsr_reload)            cnt_reload++;
    if (lfsr_en && busy)        cnt_skip++;
    if (busy)                   cnt_busy++;
    if (paint)                  cnt_paint++;
    if (lfsr_en && !busy)       cnt_arm_en++;
    if (lfsr_reload && lfsr_en) cnt_both++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_reload"},  lfsr_reload, 0);
    check({tag, "_en"},      lfsr_en,     0);
    check({tag, "_paint"},   paint,       0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_overrun"}, overrun,     0);
  endtask

  // One frame: frame_start, f_first-1 off-field cycles, FH rows with blanking, then a short tail.
  task automatic run_frame(input int f_first, input logic [SPDW-1:0] spd,
                           input bit restart, input bit pz);
    int exp_skip;
    speed = spd;
    pause = pz;
    if (m_armed && !(PAUSE_ON && pz)) m_offset = (m_offset + int'(spd)) % FW;
    if (restart && m_offset != 0) begin
      step(1'b1, -1, -1);
      step(1'b0, -1, -1);
      m_overrun = 1'b1;
    end
    clear_counts();
    step(1'b1, -1, -1);
    check("reload_lag", lfsr_reload, 1);
    for (int i = 1; i < f_first; i++) begin
      if (i % 2 == 0) step(1'b0, -(1 + int'($urandom_range(0, 7))), int'($urandom_range(0, FH-1)));
      else            step(1'b0, int'($urandom_range(0, FW-1)), -1);
    end
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) step(1'b0, x, y);
      step(1'b0, FW, y);
      step(1'b0, FW + 3, y);
      step(1'b0, -1, y);
    end
    step(1'b0, 0, FH);
    step(1'b0, FW - 1, FH);

    if (f_first <= m_offset) begin
      exp_skip  = f_first - 1;
      m_overrun = 1'b1;
    end else begin
      exp_skip = m_offset;
    end
    m_armed = 1'b1;

    check("reload_count", cnt_reload, 1);
    check("skip_pulses",  cnt_skip,   exp_skip);
    check("busy_cycles",  cnt_busy,   exp_skip + 1);
    check("paint_pulses", cnt_paint,  FW * FH);
    check("armed_en",     cnt_arm_en, FW * FH);
    check("reload_en_overlap", cnt_both, 0);
    check("overrun", overrun, m_overrun);
  endtask

  // Reset lands mid-frame together with a frame_start; reset must win.
  task automatic rst_mid(input logic [SPDW-1:0] spd);
    speed = spd;
    step(1'b1, -1, -1);
    step(1'b0, -1, -1);
    step(1'b0, -1, -1);
    rst = 1'b1;
    step(1'b1, -1, -1);
    rst = 1'b0;
    check_zero("rst_mid");
    step(1'b0, 5, 1);
    check_zero("idle_hold");
    m_offset  = 0;
    m_armed   = 1'b0;
    m_overrun = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    dx = -1;
    dy = -1;
    speed = '0;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    step(1'b0, 3, 2);
    check_zero("idle");

    // Constant speed 3: offsets 0, 3, 6
    run_frame(40, 8'd3, 1'b0, 1'b0);
    run_frame(40, 8'd3, 1'b0, 1'b0);
    run_frame(40, 8'd3, 1'b0, 1'b0);
    rst_mid(8'd3);

    // Maximum speed wraps: offsets 0, 31, 30, 29
    run_frame(40, 8'd255, 1'b0, 1'b0);
    run_frame(40, 8'd255, 1'b0, 1'b0);
    run_frame(40, 8'd255, 1'b0, 1'b0);
    run_frame(40, 8'd255, 1'b0, 1'b0);

    // Offset 30 with the field arriving at cycle 10: skip cut short after 9 pulses
    run_frame(10, 8'd1, 1'b0, 1'b0);
    // Early frame_start during the skip, offset 3
    run_frame(40, 8'd5, 1'b1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      run_frame(int'($urandom_range(2, 60)), SPDW'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    rst_mid(SPDW'($urandom));
    run_frame(40, 8'd9, 1'b0, 1'b0);
    run_frame(40, 8'd9, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
